// File: rtl/cdb_arbiter_if.sv
// Bundle of the CDB arbiter's request and broadcast signals.
// The RS side uses the master modport; the arbiter uses the slave modport.
interface cdb_arbiter_if #(
  parameter int N     = 7,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
);
  // Handshake: an entry raises req[i] with its tag and data and holds all three
  // stable until grant[i] is seen. grant[i] is a one-cycle pulse meaning the
  // result is on the CDB in that cycle. The entry drops req at the edge that
  // ends the grant cycle, and may raise it again on the following cycle.
  logic                flush;
  logic [N-1:0]        req;
  logic [N*TAG_W-1:0]  req_tag;
  logic [N*XLEN-1:0]   req_data;
  logic [N-1:0]        grant;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [XLEN-1:0]     cdb_data;

  modport master (
    output flush, req, req_tag, req_data,
    input  grant, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  flush, req, req_tag, req_data,
    output grant, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. Each cycle it picks one ready
// RS entry, registers that entry's tag and result onto the CDB, and pulses its grant.
module cdb_arbiter #(
  parameter  int N     = 7,
  parameter  int TAG_W = 5,
  parameter  int XLEN  = 32,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  cdb_arbiter_if.slave     bus,
  output logic [PTR_W-1:0] ptr
);

  logic [N-1:0]     elig;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] ptr_nxt;
  logic [N-1:0]     grant_nxt;
  logic [TAG_W-1:0] win_tag;
  logic [XLEN-1:0]  win_data;

  // The entry holding the grant this cycle is masked, so it cannot win twice.
  always_comb begin
    elig  = bus.req & ~bus.grant;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    win_tag   = '0;
    win_data  = '0;
    grant_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (PTR_W'(i) == win) begin
        win_tag      = bus.req_tag[i*TAG_W +: TAG_W];
        win_data     = bus.req_data[i*XLEN +: XLEN];
        grant_nxt[i] = found;
      end
    end
    // N need not be a power of two, so the wrap is explicit.
    ptr_nxt = (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant     <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      ptr           <= '0;
    end else if (bus.flush) begin
      bus.grant     <= '0;
      bus.cdb_valid <= 1'b0;
    end else if (found) begin
      bus.grant     <= grant_nxt;
      bus.cdb_valid <= 1'b1;
      bus.cdb_tag   <= win_tag;
      bus.cdb_data  <= win_data;
      ptr           <= ptr_nxt;
    end else begin
      // Idle: tag and data keep the last broadcast.
      bus.grant     <= '0;
      bus.cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin order, wrap, mask,
// flush and asynchronous reset, with hand-computed expected values.
module tb_cdb_arbiter;
  localparam int N     = 7;
  localparam int TAG_W = 5;
  localparam int XLEN  = 32;

  logic clk;
  logic rst;
  logic [2:0] ptr;

  cdb_arbiter_if #(.N(N), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  cdb_arbiter #(.N(N), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ptr (ptr)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req;
  logic             flush;
  logic [TAG_W-1:0] tags [N];
  logic [XLEN-1:0]  datas [N];
  logic [N-1:0]     last_g;
  logic             auto_drop;

  assign bus.req   = req;
  assign bus.flush = flush;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i*TAG_W +: TAG_W] = tags[i];
      bus.req_data[i*XLEN +: XLEN]  = datas[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: advance one edge, then model the requesters dropping req at the
  // edge that ends their grant cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~last_g;
    last_g = bus.grant;
  endtask

  task automatic check_bcast(input string tag, input int idx, input logic [2:0] exp_ptr);
    check({tag, "_grant"}, 64'(bus.grant), 64'(7'(1) << idx));
    check({tag, "_valid"}, 64'(bus.cdb_valid), 64'd1);
    check({tag, "_tag"},   64'(bus.cdb_tag), 64'(tags[idx]));
    check({tag, "_data"},  64'(bus.cdb_data), 64'(datas[idx]));
    check({tag, "_ptr"},   64'(ptr), 64'(exp_ptr));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 64'(bus.grant), 64'd0);
    check({tag, "_valid"}, 64'(bus.cdb_valid), 64'd0);
  endtask

  // Bus-wide invariants checked away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_valid_or_grant", 64'(bus.cdb_valid), 64'(|bus.grant));
      check("inv_onehot", 64'($countones(bus.grant) <= 1), 64'd1);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (req[i]) assert (tags[i] != '0) else $error("requesting entry %0d has tag 0", i);
  end

  initial begin
    tags  = '{5'h11, 5'h12, 5'h13, 5'h03, 5'h15, 5'h16, 5'h17};
    datas = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hDEAD_BEEF,
              32'hA000_0004, 32'hA000_0005, 32'hA000_0006};
    rst       = 1'b1;
    flush     = 1'b0;
    req       = 7'h7F;
    last_g    = '0;
    auto_drop = 1'b1;

    // 1: reset holds everything at zero even with all entries requesting
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_tag",   64'(bus.cdb_tag), 64'd0);
    check("rst_data",  64'(bus.cdb_data), 64'd0);
    check("rst_ptr",   64'(ptr), 64'd0);
    #3 rst = 1'b0;

    // 2: round-robin 0..6 with no gaps, then idle with tag/data held
    step();
    check_bcast("rr0", 0, 3'd1);
    for (int i = 1; i < N; i++) begin
      step();
      check_bcast($sformatf("rr%0d", i), i, (i == N - 1) ? 3'd0 : 3'(i + 1));
    end
    step();
    check_idle("rr_idle");
    check("rr_hold_tag",  64'(bus.cdb_tag), 64'h17);
    check("rr_hold_data", 64'(bus.cdb_data), 64'hA000_0006);
    check("rr_hold_ptr",  64'(ptr), 64'd0);

    // 3: wrap from ptr=5 with entries 2 and 6 requesting
    step();
    req = 7'b001_0000;
    step();
    check_bcast("wr4", 4, 3'd5);
    req = req | 7'b100_0100;
    step();
    check_bcast("wr6", 6, 3'd0);
    step();
    check_bcast("wr2", 2, 3'd3);
    step();
    check_idle("wr_idle");
    check("wr_ptr", 64'(ptr), 64'd3);

    // 4: lone requester that never drops is granted every other cycle
    auto_drop = 1'b0;
    req = 7'b000_1000;
    for (int r = 0; r < 2; r++) begin
      step();
      check_bcast($sformatf("mask_on%0d", r), 3, 3'd4);
      step();
      check_idle($sformatf("mask_off%0d", r));
      check($sformatf("mask_hold_tag%0d", r), 64'(bus.cdb_tag), 64'h03);
    end
    req = '0;
    auto_drop = 1'b1;
    step();
    check_idle("mask_end");

    // 5: flush at the arbitration edge beats the requests
    req   = 7'h0C;
    flush = 1'b1;
    step();
    check_idle("fl_kill");
    check("fl_ptr", 64'(ptr), 64'd4);
    flush = 1'b0;
    step();
    check_bcast("fl2", 2, 3'd3);
    step();
    check_bcast("fl3", 3, 3'd4);
    step();
    check_idle("fl_idle");

    // 6: asynchronous reset between edges during a broadcast
    req = 7'b000_0010;
    step();
    check_bcast("ar1", 1, 3'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_grant", 64'(bus.grant), 64'd0);
    check("ar_valid", 64'(bus.cdb_valid), 64'd0);
    check("ar_tag",   64'(bus.cdb_tag), 64'd0);
    check("ar_data",  64'(bus.cdb_data), 64'd0);
    check("ar_ptr",   64'(ptr), 64'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check_idle("ar_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
